reg_writeback: RTL and testbench

Writeback stage that sits directly upstream of the 16 x 32-bit register file's write port. It merges single-cycle ALU results and variable-latency load results into the register file's single write port, buffering loads in a small queue. It also keeps a per-register pending-write scoreboard so decode can stall on RAW/WAW hazards without forwarding.

---
 rtl/reg_writeback.sv | 133 +++++++++++++
 tb/tb_reg_writeback.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Writeback stage: merges ALU and queued load results onto the single
// register-file write port and tracks pending writes for decode hazards.
module reg_writeback #(
    parameter int NREGS    = 16,
    parameter int AW       = 4,
    parameter int DW       = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic [AW-1:0]    chk_rs1,
    input  logic [AW-1:0]    chk_rs2,
    input  logic [AW-1:0]    chk_rd,
    output logic             hazard,
    output logic [NREGS-1:0] busy,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [AW-1:0]    alu_rd,
    input  logic [DW-1:0]    alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [AW-1:0]    mem_rd,
    input  logic [DW-1:0]    mem_data,
    output logic [AW-1:0]    rf_rd,
    output logic [DW-1:0]    rf_write_data,
    output logic             rf_reg_write
);

    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(LQ_DEPTH);

    logic [AW-1:0]    r_lq_rd   [LQ_DEPTH];
    logic [DW-1:0]    r_lq_data [LQ_DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [NREGS-1:0] r_busy;
    logic [AW-1:0]    r_rf_rd;
    logic [DW-1:0]    r_rf_data;
    logic             r_rf_we;

    logic             w_full;
    logic             w_empty;
    logic             w_sel_lq;
    logic             w_sel_alu;
    logic             w_win;
    logic [AW-1:0]    w_wr_rd;
    logic [DW-1:0]    w_wr_data;
    logic             w_push;
    logic             w_pop;
    logic [NREGS-1:0] w_busy_nxt;

    assign w_full  = (r_count == FULL);
    assign w_empty = (r_count == '0);

    // Ready looks only at the current count: a full queue never accepts,
    // even while its head is being drained this cycle.
    assign mem_ready = !rst && !w_full;
    assign alu_ready = !rst && !w_full;

    // A full queue outranks the ALU so loads cannot be starved.
    assign w_sel_lq  = w_full || (!alu_valid && !w_empty);
    assign w_sel_alu = !w_full && alu_valid;
    assign w_win     = w_sel_lq || w_sel_alu;
    assign w_wr_rd   = w_sel_lq ? r_lq_rd[r_head]   : alu_rd;
    assign w_wr_data = w_sel_lq ? r_lq_data[r_head] : alu_data;

    assign w_push = mem_valid && mem_ready;
    assign w_pop  = w_sel_lq;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lq_rd[r_tail]   <= mem_rd;
            r_lq_data[r_tail] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_we <= w_win && (w_wr_rd != '0);
            if (w_win) begin
                r_rf_rd   <= w_wr_rd;
                r_rf_data <= w_wr_data;
            end
        end
    end

    // A re-issue in the same cycle as the retiring write keeps the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            if (issue_valid && issue_rd == AW'(i))
                w_busy_nxt[i] = 1'b1;
            else if (r_rf_we && r_rf_rd == AW'(i))
                w_busy_nxt[i] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign hazard = ((chk_rs1 != '0) && r_busy[chk_rs1])
                 || ((chk_rs2 != '0) && r_busy[chk_rs2])
                 || ((chk_rd  != '0) && r_busy[chk_rd]);

    assign busy          = r_busy;
    assign rf_rd         = r_rf_rd;
    assign rf_write_data = r_rf_data;
    assign rf_reg_write  = r_rf_we;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed table, reset-flush sequence and
// randomized traffic against a queue-based reference model.
module tb_reg_writeback;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [3:0]  issue_rd;
    logic [3:0]  chk_rs1;
    logic [3:0]  chk_rs2;
    logic [3:0]  chk_rd;
    logic        hazard;
    logic [15:0] busy;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_rd;
    logic [31:0] mem_data;
    logic [3:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic        rf_reg_write;

    reg_writeback dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .busy(busy),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_rd(rf_rd), .rf_write_data(rf_write_data),
        .rf_reg_write(rf_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [3:0]  ird;
        logic        av;
        logic [3:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [3:0]  mrd;
        logic [31:0] md;
        logic [3:0]  c1;
        logic        eh;
        logic        ear;
        logic        emr;
        logic        ewe;
        logic [3:0]  erd;
        logic [31:0] ed;
        logic [15:0] eb;
    } vec_t;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
    } ent_t;

    int n_vec = 0;
    int n_err = 0;

    ent_t        mq[$];
    logic [15:0] m_busy = '0;
    logic        m_we = 1'b0;
    logic [3:0]  m_rd = '0;
    logic [31:0] m_data = '0;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic iv, input logic [3:0] ird,
        input logic av, input logic [3:0] ard, input logic [31:0] ad,
        input logic mv, input logic [3:0] mrd, input logic [31:0] md,
        input logic [3:0] c1,
        input logic eh, input logic ear, input logic emr,
        input logic ewe, input logic [3:0] erd, input logic [31:0] ed,
        input logic [15:0] eb);
        vec_t v;
        v.iv = iv; v.ird = ird; v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md; v.c1 = c1;
        v.eh = eh; v.ear = ear; v.emr = emr;
        v.ewe = ewe; v.erd = erd; v.ed = ed; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge following the writeback rules.
    task automatic model_edge();
        logic        win;
        logic        full;
        logic [3:0]  wr;
        logic [31:0] wd;
        logic [15:0] nb;
        win = 1'b0; wr = '0; wd = '0;
        if (rst) begin
            mq.delete();
            m_busy = '0; m_we = 1'b0; m_rd = '0; m_data = '0;
        end else begin
            full = (mq.size() == 2);
            if (full || (!alu_valid && mq.size() > 0)) begin
                wr = mq[0].rd; wd = mq[0].data;
                void'(mq.pop_front());
                win = 1'b1;
            end else if (alu_valid) begin
                wr = alu_rd; wd = alu_data; win = 1'b1;
            end
            nb = m_busy;
            if (m_we) nb[m_rd] = 1'b0;
            if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
            m_busy = nb;
            if (mem_valid && !full) mq.push_back('{rd: mem_rd, data: mem_data});
            m_we = win && (wr != 0);
            if (win) begin
                m_rd = wr; m_data = wd;
            end
        end
    endtask

    function automatic logic m_hazard();
        return (chk_rs1 != 0 && m_busy[chk_rs1])
            || (chk_rs2 != 0 && m_busy[chk_rs2])
            || (chk_rd  != 0 && m_busy[chk_rd]);
    endfunction

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_rd = v.ird;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md;
        chk_rs1 = v.c1;
    endtask

    task automatic step_tbl(input vec_t v, input int idx);
        drive(v);
        chk_rs2 = '0; chk_rd = '0;
        #1;
        chk($sformatf("t%0d hazard", idx), 32'(hazard), 32'(v.eh));
        chk($sformatf("t%0d alu_ready", idx), 32'(alu_ready), 32'(v.ear));
        chk($sformatf("t%0d mem_ready", idx), 32'(mem_ready), 32'(v.emr));
        @(posedge clk);
        model_edge();
        #1;
        chk($sformatf("t%0d rf_reg_write", idx), 32'(rf_reg_write), 32'(v.ewe));
        chk($sformatf("t%0d rf_rd", idx), 32'(rf_rd), 32'(v.erd));
        chk($sformatf("t%0d rf_write_data", idx), rf_write_data, v.ed);
        chk($sformatf("t%0d busy", idx), 32'(busy), 32'(v.eb));
    endtask

    task automatic step_model(input string tag);
        logic er;
        er = !rst && (mq.size() < 2);
        #1;
        chk({tag, " hazard"}, 32'(hazard), 32'(m_hazard()));
        chk({tag, " alu_ready"}, 32'(alu_ready), 32'(er));
        chk({tag, " mem_ready"}, 32'(mem_ready), 32'(er));
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, " rf_reg_write"}, 32'(rf_reg_write), 32'(m_we));
        chk({tag, " rf_rd"}, 32'(rf_rd), 32'(m_rd));
        chk({tag, " rf_write_data"}, rf_write_data, m_data);
        chk({tag, " busy"}, 32'(busy), 32'(m_busy));
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        issue_valid = 0; issue_rd = 0; chk_rs1 = 5; chk_rs2 = 0; chk_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst rf_reg_write", 32'(rf_reg_write), 32'd0);
        chk("rst rf_rd", 32'(rf_rd), 32'd0);
        chk("rst rf_write_data", rf_write_data, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst hazard", 32'(hazard), 32'd0);
        chk("rst alu_ready", 32'(alu_ready), 32'd0);
        chk("rst mem_ready", 32'(mem_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst alu_ready", 32'(alu_ready), 32'd1);
        chk("post-rst mem_ready", 32'(mem_ready), 32'd1);

        // ALU write to r5 and its hazard window
        tbl.push_back(mk(1,5, 0,0,0,       0,0,0,       5, 0,1,1, 0,0,0,       16'h0020));
        tbl.push_back(mk(0,0, 1,5,32'h1234,0,0,0,       5, 1,1,1, 1,5,32'h1234,16'h0020));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       5, 1,1,1, 0,5,32'h1234,16'h0000));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       5, 0,1,1, 0,5,32'h1234,16'h0000));
        // Same-cycle load r3 and ALU r4: ALU first
        tbl.push_back(mk(1,3, 0,0,0,       0,0,0,       0, 0,1,1, 0,5,32'h1234,16'h0008));
        tbl.push_back(mk(1,4, 0,0,0,       0,0,0,       3, 1,1,1, 0,5,32'h1234,16'h0018));
        tbl.push_back(mk(0,0, 1,4,32'h5,   1,3,32'hAAAA,4, 1,1,1, 1,4,32'h5,   16'h0018));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       4, 1,1,1, 1,3,32'hAAAA,16'h0008));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       3, 1,1,1, 0,3,32'hAAAA,16'h0000));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       3, 0,1,1, 0,3,32'hAAAA,16'h0000));
        // r0 from both paths, plus r0 issue
        tbl.push_back(mk(1,0, 1,0,32'hDEAD,1,0,32'hBEEF,0, 0,1,1, 0,0,32'hDEAD,16'h0000));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       0, 0,1,1, 0,0,32'hBEEF,16'h0000));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       0, 0,1,1, 0,0,32'hBEEF,16'h0000));
        // r7 clear coinciding with re-issue
        tbl.push_back(mk(1,7, 0,0,0,       0,0,0,       0, 0,1,1, 0,0,32'hBEEF,16'h0080));
        tbl.push_back(mk(0,0, 1,7,32'h77,  0,0,0,       7, 1,1,1, 1,7,32'h77,  16'h0080));
        tbl.push_back(mk(1,7, 0,0,0,       0,0,0,       7, 1,1,1, 0,7,32'h77,  16'h0080));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       7, 1,1,1, 0,7,32'h77,  16'h0080));
        tbl.push_back(mk(0,0, 1,7,32'h78,  0,0,0,       7, 1,1,1, 1,7,32'h78,  16'h0080));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       7, 1,1,1, 0,7,32'h78,  16'h0000));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       7, 0,1,1, 0,7,32'h78,  16'h0000));
        // Continuous ALU with three loads; producers hold until accepted
        tbl.push_back(mk(0,0, 1,1,32'h101, 1,9,32'h901, 0, 0,1,1, 1,1,32'h101, 16'h0000));
        tbl.push_back(mk(0,0, 1,1,32'h102, 1,10,32'h902,0, 0,1,1, 1,1,32'h102, 16'h0000));
        tbl.push_back(mk(0,0, 1,1,32'h103, 1,11,32'h903,0, 0,0,0, 1,9,32'h901, 16'h0000));
        tbl.push_back(mk(0,0, 1,1,32'h103, 1,11,32'h903,0, 0,1,1, 1,1,32'h103, 16'h0000));
        tbl.push_back(mk(0,0, 1,1,32'h104, 0,0,0,       0, 0,0,0, 1,10,32'h902,16'h0000));
        tbl.push_back(mk(0,0, 1,1,32'h104, 0,0,0,       0, 0,1,1, 1,1,32'h104, 16'h0000));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       0, 0,1,1, 1,11,32'h903,16'h0000));
        tbl.push_back(mk(0,0, 0,0,0,       0,0,0,       0, 0,1,1, 0,11,32'h903,16'h0000));

        foreach (tbl[i]) step_tbl(tbl[i], i);

        // Reset with two loads queued and r12 pending
        v = mk(1,12, 1,2,32'h222, 1,12,32'hC0C, 12, 0,0,0, 0,0,0,0);
        drive(v); step_model("flush a");
        v = mk(0,0, 1,2,32'h223, 1,13,32'hC0D, 12, 0,0,0, 0,0,0,0);
        drive(v); step_model("flush b");
        v = mk(0,0, 0,0,0, 0,0,0, 12, 0,0,0, 0,0,0,0);
        drive(v);
        rst = 1'b1;
        step_model("flush rst");
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush rf_reg_write", 32'(rf_reg_write), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_model("flush idle");
            chk("flush no write", 32'(rf_reg_write), 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            issue_valid = $urandom_range(0, 2) == 0;
            issue_rd = 4'($urandom);
            alu_valid = $urandom_range(0, 2) != 0;
            alu_rd = 4'($urandom_range(0, 7));
            alu_data = $urandom;
            mem_valid = $urandom_range(0, 1) == 1;
            mem_rd = 4'($urandom_range(0, 7));
            mem_data = $urandom;
            chk_rs1 = 4'($urandom);
            chk_rs2 = 4'($urandom);
            chk_rd = 4'($urandom);
            step_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
